mul_div_unit: RTL and testbench

Execute-stage multiply/divide unit for the five-stage MIPS pipeline. Accepts a mult/multu/div/divu issue from the E stage, holds `busy` for a fixed multi-cycle latency, then commits the 64-bit result into the architectural HI/LO registers. Also serves mthi/mtlo writes and mfhi/mflo reads. Its `busy` output and the E-stage start strobe feed the hazard unit's multiply/divide stall term.

---
 rtl/md_pkg.sv | 22 ++
 rtl/mul_div_unit.sv | 120 ++++++++++++
 tb/tb_mul_div_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared encodings and default latencies for the execute-stage multiply/divide unit.
package md_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam logic [1:0] MF_HI = 2'b01;
  localparam logic [1:0] MF_LO = 2'b10;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mul_div_unit.sv
// Multi-cycle mult/multu/div/divu unit owning the architectural HI/LO registers.
// The result is computed at issue and held pending until the latency counter expires.
module mul_div_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic        mt_we,
  input  logic        mt_sel,
  input  logic [1:0]  mf,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_rdata
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  md_state_e          state_q;
  logic [CW-1:0]      cnt_q;
  logic [31:0]        p_hi_q, p_lo_q;
  logic               dz_q;
  logic [31:0]        hi_q, lo_q;

  logic               is_div_d, is_signed_d, dz_d;
  logic signed [63:0] a_ext_d, b_ext_d, b_div_d, prod_d;
  logic [31:0]        quot_d, rem_d;
  logic [63:0]        res_d;

  // Sign- or zero-extend so that signed and unsigned forms share one arithmetic path.
  always_comb begin
    is_div_d    = (md_op == MD_DIV) || (md_op == MD_DIVU);
    is_signed_d = (md_op == MD_MULT) || (md_op == MD_DIV);
    a_ext_d     = is_signed_d ? {{32{srcA[31]}}, srcA} : {32'b0, srcA};
    b_ext_d     = is_signed_d ? {{32{srcB[31]}}, srcB} : {32'b0, srcB};
    dz_d        = is_div_d && (srcB == 32'b0);
    // The divisor is forced to 1 on divide-by-zero only to keep the datapath defined.
    b_div_d     = (srcB == 32'b0) ? 64'sd1 : b_ext_d;
    prod_d      = a_ext_d * b_ext_d;
    quot_d      = 32'(a_ext_d / b_div_d);
    rem_d       = 32'(a_ext_d % b_div_d);
    if (is_div_d) begin
      res_d = {rem_d, quot_d};
    end else begin
      res_d = prod_d;
    end
  end

  // Control FSM, latency counter, pending result and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      p_hi_q  <= 32'b0;
      p_lo_q  <= 32'b0;
      dz_q    <= 1'b0;
      hi_q    <= 32'b0;
      lo_q    <= 32'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_RUN;
            cnt_q   <= is_div_d ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            p_hi_q  <= res_d[63:32];
            p_lo_q  <= res_d[31:0];
            dz_q    <= dz_d;
          end else if (mt_we) begin
            if (mt_sel) begin
              hi_q <= srcA;
            end else begin
              lo_q <= srcA;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= ST_IDLE;
            if (!dz_q) begin
              hi_q <= p_hi_q;
              lo_q <= p_lo_q;
            end else begin
              hi_q <= hi_q;
            end
          end else begin
            state_q <= ST_RUN;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign busy = (state_q == ST_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Read port has no bypass of pending results; the hazard unit stalls on busy|start.
  always_comb begin
    case (mf)
      MF_HI:   md_rdata = hi_q;
      MF_LO:   md_rdata = lo_q;
      default: md_rdata = 32'b0;
    endcase
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus queues expected HI/LO and busy length,
// a negedge monitor checks each completed operation when busy falls.
module tb_mul_div_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, mt_we, mt_sel;
  logic [1:0]  md_op, mf;
  logic [31:0] srcA, srcB;
  logic        busy;
  logic [31:0] hi, lo, md_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } exp_t;

  exp_t sb_q[$];

  mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .srcA(srcA), .srcB(srcB), .mt_we(mt_we), .mt_sel(mt_sel), .mf(mf),
    .busy(busy), .hi(hi), .lo(lo), .md_rdata(md_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input string name, input logic [31:0] h, input logic [31:0] l, input int n);
    exp_t e;
    e.name = name; e.hi = h; e.lo = l; e.n = n;
    sb_q.push_back(e);
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    md_op = op; srcA = a; srcB = b; start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 40 && busy; i++) step(1);
    check({name, "_timeout"}, {31'b0, busy}, 32'b0);
  endtask

  // Monitor: count busy cycles and compare the committed HI/LO when busy drops.
  int  busy_cnt = 0;
  bit  prev_busy = 1'b0;
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      busy_cnt  = 0;
      prev_busy = 1'b0;
    end else begin
      if (busy === 1'b1) begin
        busy_cnt++;
      end else if (prev_busy) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got hi=%h lo=%h expected no completion", hi, lo);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check({e.name, "_busy"}, 32'(busy_cnt), 32'(e.n));
          check({e.name, "_hi"}, hi, e.hi);
          check({e.name, "_lo"}, lo, e.lo);
        end
        busy_cnt = 0;
      end
      prev_busy = (busy === 1'b1);
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; mt_we = 1'b0; mt_sel = 1'b0;
    md_op = MD_MULT; mf = MF_HI; srcA = 32'b0; srcB = 32'b0;
    step(2);
    check("rst_busy", {31'b0, busy}, 32'b0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_rdata", md_rdata, 32'h0);
    reset = 1'b0;
    step(1);

    // Reset during busy cycle 2 aborts without a later commit.
    issue(MD_MULT, 32'd3, 32'd4);
    step(1);
    reset = 1'b1;
    step(1);
    check("abort_busy", {31'b0, busy}, 32'b0);
    check("abort_lo", lo, 32'h0);
    reset = 1'b0;
    step(12);
    check("abort_late_busy", {31'b0, busy}, 32'b0);
    check("abort_late_hi", hi, 32'h0);
    check("abort_late_lo", lo, 32'h0);

    push("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFB, 5);
    issue(MD_MULT, 32'hFFFF_FFFF, 32'd5);
    wait_idle("mult_neg");
    push("multu", 32'h0000_0004, 32'hFFFF_FFFB, 5);
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'd5);
    wait_idle("multu");
    push("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle("div_neg");
    push("divu", 32'h1, 32'h3, 10);
    issue(MD_DIVU, 32'd7, 32'd2);
    wait_idle("divu");
    push("div_wrap", 32'h0, 32'h8000_0000, 10);
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle("div_wrap");

    // Preload HI/LO then divide by zero: they must survive.
    mt_we = 1'b1; mt_sel = 1'b1; srcA = 32'h11;
    step(1);
    mt_sel = 1'b0; srcA = 32'h22;
    step(1);
    mt_we = 1'b0;
    check("mthi", hi, 32'h11);
    check("mtlo", lo, 32'h22);
    push("div_zero", 32'h11, 32'h22, 10);
    issue(MD_DIV, 32'd9, 32'd0);
    wait_idle("div_zero");

    // Second start during RUN is ignored.
    push("start_in_run", 32'h0, 32'd42, 5);
    issue(MD_MULT, 32'd6, 32'd7);
    step(1);
    issue(MD_MULT, 32'd100, 32'd100);
    wait_idle("start_in_run");

    // start and mt_we together: the write is dropped.
    push("start_mt", 32'h0, 32'd27, 5);
    md_op = MD_MULT; srcA = 32'd3; srcB = 32'd9; start = 1'b1;
    mt_we = 1'b1; mt_sel = 1'b0;
    step(1);
    start = 1'b0; mt_we = 1'b0;
    check("start_mt_drop", lo, 32'd42);
    wait_idle("start_mt");

    // mtlo while busy has no effect.
    push("mt_busy", 32'h0, 32'd6, 5);
    issue(MD_MULT, 32'd2, 32'd3);
    mt_we = 1'b1; mt_sel = 1'b0; srcA = 32'hDEAD;
    step(1);
    mt_we = 1'b0;
    check("mt_busy_ignored", lo, 32'd27);
    wait_idle("mt_busy");

    // Read path.
    step(1);
    mt_we = 1'b1; mt_sel = 1'b1; srcA = 32'hA;
    step(1);
    mt_sel = 1'b0; srcA = 32'hB;
    step(1);
    mt_we = 1'b0;
    mf = MF_HI;   #1; check("rd_hi", md_rdata, 32'hA);
    mf = MF_LO;   #1; check("rd_lo", md_rdata, 32'hB);
    mf = 2'b00;   #1; check("rd_00", md_rdata, 32'h0);
    mf = 2'b11;   #1; check("rd_11", md_rdata, 32'h0);

    step(3);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
